pixel_write_arbiter: RTL and testbench

- Downstream of the character index writer and the trajectory plotter. It takes their 19-bit/3-bit pixel write strobes and drives the single write port of the 640x480 frame-buffer RAM.
- Each source gets its own small FIFO. The two FIFOs drain round-robin, one RAM write per cycle, so simultaneous text and missile drawing never collide or lose pixels silently.

---
 rtl/pixel_write_arbiter_pkg.sv | 25 ++
 rtl/pixel_write_arbiter_fifo.sv | 50 +++++
 rtl/pixel_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants and types for the frame-buffer write arbiter: pixel geometry,
// entry packing and the arbiter/sweep state encodings.
package pixel_write_arbiter_pkg;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 3;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIXELS   = SCREEN_W * SCREEN_H;
    localparam logic [DATA_W-1:0] BG_COLOR = 3'b000;

    // Operating mode of the write port: draining the FIFOs or sweeping the frame.
    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    // Which source owns the RAM port on a given edge.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/pixel_write_arbiter_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed {address, colour}
// pixel writes; a push into a full FIFO is accepted only when it pops the same edge.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 22
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Merges the text-writer (A) and trajectory-plotter (B) pixel strobes onto the single
// frame-buffer write port. Optional full-screen clear sweep: PIXEL_WRITE_ARBITER_CLEAR_EN.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = pixel_write_arbiter_pkg::ADDR_W,
    parameter int DATA_W = pixel_write_arbiter_pkg::DATA_W,
    parameter int PIXELS = pixel_write_arbiter_pkg::PIXELS,
    parameter logic [DATA_W-1:0] BG_COLOR = pixel_write_arbiter_pkg::BG_COLOR
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_wenable,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_wenable,
    output logic              b_ready,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wenable,
    output logic              a_overflow,
    output logic              b_overflow,
    input  logic              overflow_clear,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              idle
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] a_dout, b_dout;
    logic [CNT_W-1:0]   a_count, b_count;
    logic               a_full, b_full, a_empty, b_empty;
    logic               a_push, b_push, a_drop, b_drop;
    logic               hold;
    grant_e             grant;
    logic               last_b;

    logic [ADDR_W-1:0]  nxt_waddr;
    logic [DATA_W-1:0]  nxt_wdata;
    logic               nxt_wenable;

    // A write into a full FIFO still lands if that FIFO is being drained this edge.
    assign a_push = a_wenable && (!a_full || grant == GNT_A);
    assign b_push = b_wenable && (!b_full || grant == GNT_B);
    assign a_drop = a_wenable && !a_push;
    assign b_drop = b_wenable && !b_push;

    assign a_ready = (a_count < CNT_W'(DEPTH));
    assign b_ready = (b_count < CNT_W'(DEPTH));
    assign idle    = a_empty && b_empty && !ram_wenable && !clear_busy;

    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo_a (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (a_push),
        .pop     (grant == GNT_A),
        .din     ({a_waddr, a_wdata}),
        .dout    (a_dout),
        .count   (a_count),
        .full    (a_full),
        .empty   (a_empty)
    );

    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo_b (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (b_push),
        .pop     (grant == GNT_B),
        .din     ({b_waddr, b_wdata}),
        .dout    (b_dout),
        .count   (b_count),
        .full    (b_full),
        .empty   (b_empty)
    );

`ifdef PIXEL_WRITE_ARBITER_CLEAR_EN
    arb_state_e        state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              clear_start;
    logic              sweeping;

    // The sweep state lingers one edge past the last address so that edge can drain.
    assign clear_start = clear_req && (state == ST_DRAIN);
    assign sweeping    = (state == ST_CLEAR) && (sweep_cnt != ADDR_W'(PIXELS));
    assign hold        = clear_start || sweeping;
    assign clear_busy  = (state == ST_CLEAR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_DRAIN;
            sweep_cnt <= '0;
        end else begin
            case (state)
                ST_DRAIN: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        sweep_cnt <= ADDR_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (sweeping) sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    else          state     <= ST_DRAIN;
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end
`else
    logic unused_clear_req;
    localparam int unused_sweep_cfg = PIXELS + int'(BG_COLOR);

    assign unused_clear_req = clear_req;
    assign hold             = 1'b0;
    assign clear_busy       = 1'b0;
`endif

    // Round robin: on a tie the source not granted last time wins.
    always_comb begin
        grant = GNT_NONE;
        if (!hold) begin
            if (!a_empty && (b_empty || last_b)) grant = GNT_A;
            else if (!b_empty)                   grant = GNT_B;
        end
    end

    always_comb begin
        nxt_waddr   = ram_waddr;
        nxt_wdata   = ram_wdata;
        nxt_wenable = 1'b0;
        case (grant)
            GNT_A: begin
                {nxt_waddr, nxt_wdata} = a_dout;
                nxt_wenable            = 1'b1;
            end
            GNT_B: begin
                {nxt_waddr, nxt_wdata} = b_dout;
                nxt_wenable            = 1'b1;
            end
            default: ;
        endcase
`ifdef PIXEL_WRITE_ARBITER_CLEAR_EN
        if (clear_start) begin
            nxt_waddr   = '0;
            nxt_wdata   = BG_COLOR;
            nxt_wenable = 1'b1;
        end else if (sweeping) begin
            nxt_waddr   = sweep_cnt;
            nxt_wdata   = BG_COLOR;
            nxt_wenable = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_waddr   <= '0;
            ram_wdata   <= '0;
            ram_wenable <= 1'b0;
            last_b      <= 1'b1;
            a_overflow  <= 1'b0;
            b_overflow  <= 1'b0;
        end else begin
            ram_waddr   <= nxt_waddr;
            ram_wdata   <= nxt_wdata;
            ram_wenable <= nxt_wenable;
            if (grant == GNT_A)      last_b <= 1'b0;
            else if (grant == GNT_B) last_b <= 1'b1;
            // A drop on the same edge as overflow_clear leaves the flag set.
            if (a_drop)              a_overflow <= 1'b1;
            else if (overflow_clear) a_overflow <= 1'b0;
            if (b_drop)              b_overflow <= 1'b1;
            else if (overflow_clear) b_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: reset, single write, contention ordering,
// overflow and full-with-pop, reset mid-drain, and the clear sweep when enabled.
module tb_pixel_write_arbiter;

    localparam int TB_PIXELS = 32;

    logic        clock;
    logic        reset_n;
    logic [18:0] a_waddr, b_waddr;
    logic [2:0]  a_wdata, b_wdata;
    logic        a_wenable, b_wenable;
    logic        a_ready, b_ready;
    logic [18:0] ram_waddr;
    logic [2:0]  ram_wdata;
    logic        ram_wenable;
    logic        a_overflow, b_overflow;
    logic        overflow_clear;
    logic        clear_req;
    logic        clear_busy;
    logic        idle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    int          got_cyc[$];

    pixel_write_arbiter #(
        .DEPTH  (16),
        .PIXELS (TB_PIXELS)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .a_waddr        (a_waddr),
        .a_wdata        (a_wdata),
        .a_wenable      (a_wenable),
        .a_ready        (a_ready),
        .b_waddr        (b_waddr),
        .b_wdata        (b_wdata),
        .b_wenable      (b_wenable),
        .b_ready        (b_ready),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .ram_wenable    (ram_wenable),
        .a_overflow     (a_overflow),
        .b_overflow     (b_overflow),
        .overflow_clear (overflow_clear),
        .clear_req      (clear_req),
        .clear_busy     (clear_busy),
        .idle           (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM write monitor, sampled on the inactive edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (ram_wenable) begin
            got_q.push_back({ram_waddr, ram_wdata});
            got_cyc.push_back(cyc);
        end
        if (clear_busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        a_waddr = '0; a_wdata = '0; a_wenable = 1'b0;
        b_waddr = '0; b_wdata = '0; b_wenable = 1'b0;
        overflow_clear = 1'b0;
        clear_req      = 1'b0;
    endtask

    task automatic reset_dut();
        quiet_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, idle}, 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check($sformatf("%s[%0d]", tag, k), got_q[k], exp_q[k]);
        end
    endtask

    initial begin
        int a_acc[$];
        int b_acc[$];

        // Reset held with random inputs.
        reset_n = 1'b0;
        repeat (4) begin
            a_waddr = 19'($urandom); a_wdata = 3'($urandom);
            b_waddr = 19'($urandom); b_wdata = 3'($urandom);
            a_wenable = 1'($urandom_range(0, 1));
            b_wenable = 1'($urandom_range(0, 1));
            overflow_clear = 1'($urandom_range(0, 1));
            clear_req      = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("rst_wen",    {31'd0, ram_wenable}, 32'd0);
            check("rst_a_ready",{31'd0, a_ready},     32'd1);
            check("rst_b_ready",{31'd0, b_ready},     32'd1);
            check("rst_a_ovf",  {31'd0, a_overflow},  32'd0);
            check("rst_b_ovf",  {31'd0, b_overflow},  32'd0);
            check("rst_busy",   {31'd0, clear_busy},  32'd0);
            check("rst_idle",   {31'd0, idle},        32'd1);
        end
        quiet_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Single write on A, then an out-of-range address on B.
        a_waddr = 19'h00100; a_wdata = 3'b101; a_wenable = 1'b1;
        tick();
        a_wenable = 1'b0;
        check("single_pre_wen",  {31'd0, ram_wenable}, 32'd0);
        check("single_pre_idle", {31'd0, idle},        32'd0);
        tick();
        check("single_wen",   {31'd0, ram_wenable}, 32'd1);
        check("single_addr",  {13'd0, ram_waddr},   32'h00100);
        check("single_data",  {29'd0, ram_wdata},   32'd5);
        tick();
        check("single_post_wen",  {31'd0, ram_wenable}, 32'd0);
        check("single_post_idle", {31'd0, idle},        32'd1);
        check("single_hold_addr", {13'd0, ram_waddr},   32'h00100);

        b_waddr = 19'h7FFFF; b_wdata = 3'b111; b_wenable = 1'b1;
        tick();
        b_wenable = 1'b0;
        tick();
        check("high_addr", {13'd0, ram_waddr}, 32'h7FFFF);
        check("high_data", {29'd0, ram_wdata}, 32'd7);

        // Contention: A addr 0..7 and B addr 100..107 pushed together.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            a_waddr = 19'(i);       a_wdata = i[2:0];  a_wenable = 1'b1;
            b_waddr = 19'(100 + i); b_wdata = ~i[2:0]; b_wenable = 1'b1;
            tick();
        end
        a_wenable = 1'b0; b_wenable = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({19'(i), i[2:0]});
            exp_q.push_back({19'(100 + i), ~i[2:0]});
        end
        compare_stream("contention");
        if (got_cyc.size() >= 16) check("contention_span", got_cyc[15] - got_cyc[0], 32'd15);

        // Overflow: both sources push 40 cycles; A drops at edges 32,34,36,38 and
        // B at 31,33,35,37,39. Edge 31 is A full while popped: push accepted.
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            a_waddr = 19'h01000 + 19'(i); a_wdata = i[2:0];  a_wenable = 1'b1;
            b_waddr = 19'h02000 + 19'(i); b_wdata = ~i[2:0]; b_wenable = 1'b1;
            tick();
            if (i == 29) check("ovf_a_ready_29", {31'd0, a_ready}, 32'd1);
            if (i == 29) check("ovf_b_ready_29", {31'd0, b_ready}, 32'd0);
            if (i == 30) check("ovf_a_ready_30", {31'd0, a_ready}, 32'd0);
            if (i == 30) check("ovf_b_flag_30",  {31'd0, b_overflow}, 32'd0);
            if (i == 31) check("full_pop_a_ovf", {31'd0, a_overflow}, 32'd0);
            if (i == 31) check("full_pop_a_rdy", {31'd0, a_ready}, 32'd0);
            if (i == 31) check("ovf_b_flag_31",  {31'd0, b_overflow}, 32'd1);
            if (i == 32) check("ovf_a_flag_32",  {31'd0, a_overflow}, 32'd1);
        end
        a_wenable = 1'b0; b_wenable = 1'b0;
        wait_idle(300);
        for (int i = 0; i < 40; i++) begin
            if (!(i == 32 || i == 34 || i == 36 || i == 38)) a_acc.push_back(i);
            if (!(i == 31 || i == 33 || i == 35 || i == 37 || i == 39)) b_acc.push_back(i);
        end
        for (int k = 0; k < 36; k++) begin
            exp_q.push_back({19'h01000 + 19'(a_acc[k]), a_acc[k][2:0]});
            if (k < 35) exp_q.push_back({19'h02000 + 19'(b_acc[k]), ~b_acc[k][2:0]});
        end
        compare_stream("overflow");
        check("ovf_a_sticky", {31'd0, a_overflow}, 32'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_a_cleared", {31'd0, a_overflow}, 32'd0);
        check("ovf_b_cleared", {31'd0, b_overflow}, 32'd0);

        // Reset asserted between edges while draining.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            a_waddr = 19'h00300 + 19'(i); a_wdata = i[2:0]; a_wenable = 1'b1;
            tick();
        end
        a_wenable = 1'b0;
        check("mid_drain_wen", {31'd0, ram_wenable}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_wen",  {31'd0, ram_wenable}, 32'd0);
        check("async_rst_idle", {31'd0, idle},        32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("rst_lost_wen", {31'd0, ram_wenable}, 32'd0);

`ifdef PIXEL_WRITE_ARBITER_CLEAR_EN
        // Clear sweep with three B entries queued behind it.
        reset_dut();
        busy_cnt = 0;
        clear_req = 1'b1;
        b_waddr = 19'h00400; b_wdata = 3'd1; b_wenable = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy_start", {31'd0, clear_busy}, 32'd1);
        check("clr_first_addr", {13'd0, ram_waddr},  32'd0);
        b_waddr = 19'h00401; b_wdata = 3'd2;
        tick();
        b_waddr = 19'h00402; b_wdata = 3'd3;
        tick();
        b_wenable = 1'b0;
        repeat (5) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(200);
        for (int i = 0; i < TB_PIXELS; i++) exp_q.push_back({19'(i), 3'b000});
        exp_q.push_back({19'h00400, 3'd1});
        exp_q.push_back({19'h00401, 3'd2});
        exp_q.push_back({19'h00402, 3'd3});
        compare_stream("clear");
        check("clr_busy_cycles", busy_cnt, TB_PIXELS);
        if (got_cyc.size() >= TB_PIXELS + 3)
            check("clr_span", got_cyc[TB_PIXELS + 2] - got_cyc[0], TB_PIXELS + 2);
`else
        // Without the sweep, clear_req has no effect.
        reset_dut();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("noclr_busy", {31'd0, clear_busy},  32'd0);
        check("noclr_wen",  {31'd0, ram_wenable}, 32'd0);
        tick();
        check("noclr_idle", {31'd0, idle}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
